// File: rtl/clic_irq_accept.sv
// -----------------------------------------------------------------------------
// clic_irq_accept
//
// Core-side interrupt acceptance stage that sits directly behind the CLIC.
// It filters the CLIC's winning interrupt against mie, mintthresh and the
// current interrupt level. For hardware-vectored (shv) interrupts it fetches
// the handler address from the vector table. It then presents one resolved
// interrupt (id, level, target PC, error flag) to the core. The CLIC is
// acknowledged only when the core actually takes the interrupt, so the CLIC
// never loses pending state. A withdrawn interrupt is simply re-presented by
// the CLIC later.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   irq_*_i / irq_ready_o  CLIC handshake (winning id/level/shv, 1-cycle ack)
//   mie_i, mintthresh_i,
//   cur_level_i            hart enable, threshold and current level
//   mtvec_i, mtvt_i        common handler base and vector table base
//   vec_*                  vector-table read port (req/gnt/rvalid)
//   core_irq_*             resolved interrupt towards the core
// -----------------------------------------------------------------------------
module clic_irq_accept #(
  parameter int N_SOURCE     = 256,
  parameter int IRQ_ID_WIDTH = $clog2(N_SOURCE),
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // CLIC side
  input  logic                    irq_valid_i,
  output logic                    irq_ready_o,
  input  logic [IRQ_ID_WIDTH-1:0] irq_id_i,
  input  logic [7:0]              irq_level_i,
  input  logic                    irq_shv_i,
  // hart CSR state
  input  logic                    mie_i,
  input  logic [7:0]              mintthresh_i,
  input  logic [7:0]              cur_level_i,
  input  logic [ADDR_WIDTH-1:0]   mtvec_i,
  input  logic [ADDR_WIDTH-1:0]   mtvt_i,
  // vector table read port
  output logic                    vec_req_o,
  output logic [ADDR_WIDTH-1:0]   vec_addr_o,
  input  logic                    vec_gnt_i,
  input  logic                    vec_rvalid_i,
  input  logic [ADDR_WIDTH-1:0]   vec_rdata_i,
  input  logic                    vec_err_i,
  // core side
  output logic                    core_irq_req_o,
  input  logic                    core_irq_ack_i,
  output logic [IRQ_ID_WIDTH-1:0] core_irq_id_o,
  output logic [7:0]              core_irq_level_o,
  output logic [ADDR_WIDTH-1:0]   core_irq_target_o,
  output logic                    core_irq_err_o
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_FETCH_REQ  = 2'd1;
  localparam logic [1:0] S_FETCH_WAIT = 2'd2;
  localparam logic [1:0] S_PRESENT    = 2'd3;

  // Effective level an interrupt must strictly exceed to be taken.
  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    max8 = (a > b) ? a : b;
  endfunction

  logic [1:0]              state_q,  state_d;
  logic [IRQ_ID_WIDTH-1:0] id_q,     id_d;
  logic [7:0]              level_q,  level_d;
  logic [ADDR_WIDTH-1:0]   target_q, target_d;
  logic                    err_q,    err_d;
  logic [ADDR_WIDTH-1:0]   vaddr_q,  vaddr_d;
  logic                    wd_q,     wd_d;     // withdrawal seen while fetch in flight

  logic [7:0]              floor_s;
  logic                    elig_s;
  logic                    withdraw_s;
  logic [ADDR_WIDTH-1:0]   mtvec_base_s;
  logic [ADDR_WIDTH-1:0]   vec_addr_s;

  assign floor_s      = max8(mintthresh_i, cur_level_i);
  assign elig_s       = irq_valid_i & mie_i & (irq_level_i > floor_s);
  // Withdrawal is judged on the latched level, not on whatever the CLIC shows now.
  assign withdraw_s   = ~mie_i | (level_q <= floor_s);
  assign mtvec_base_s = mtvec_i & ~ADDR_WIDTH'(3);
  // Table is 64-byte aligned, one 4-byte entry per id; the add wraps naturally.
  assign vec_addr_s   = (mtvt_i & ~ADDR_WIDTH'(63)) + (ADDR_WIDTH'(irq_id_i) << 2);

  // Next-state and latch-update logic for the acceptance FSM.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    level_d  = level_q;
    target_d = target_q;
    err_d    = err_q;
    vaddr_d  = vaddr_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (elig_s) begin
          id_d    = irq_id_i;
          level_d = irq_level_i;
          vaddr_d = vec_addr_s;
          wd_d    = 1'b0;
          if (irq_shv_i) begin
            state_d = S_FETCH_REQ;
          end else begin
            target_d = mtvec_base_s;
            err_d    = 1'b0;
            state_d  = S_PRESENT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_REQ: begin
        // A grant in the same cycle as a withdrawal commits the bus read,
        // so the withdrawal is carried into the wait state instead.
        if (vec_gnt_i) begin
          wd_d    = withdraw_s;
          state_d = S_FETCH_WAIT;
        end else if (withdraw_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH_REQ;
        end
      end
      S_FETCH_WAIT: begin
        if (vec_rvalid_i) begin
          if (vec_err_i) begin
            target_d = mtvec_base_s;
            err_d    = 1'b1;
          end else begin
            target_d = vec_rdata_i & ~ADDR_WIDTH'(1);
            err_d    = 1'b0;
          end
          if (wd_q | withdraw_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PRESENT;
          end
        end else begin
          if (withdraw_s) begin
            wd_d = 1'b1;
          end else begin
            wd_d = wd_q;
          end
          state_d = S_FETCH_WAIT;
        end
      end
      S_PRESENT: begin
        // Ack takes priority over a simultaneous withdrawal.
        if (core_irq_ack_i) begin
          state_d = S_IDLE;
        end else if (withdraw_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched interrupt registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      level_q  <= 8'd0;
      target_q <= '0;
      err_q    <= 1'b0;
      vaddr_q  <= '0;
      wd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      level_q  <= level_d;
      target_q <= target_d;
      err_q    <= err_d;
      vaddr_q  <= vaddr_d;
      wd_q     <= wd_d;
    end
  end

  assign vec_req_o         = (state_q == S_FETCH_REQ);
  assign vec_addr_o        = vaddr_q;
  assign core_irq_req_o    = (state_q == S_PRESENT);
  assign core_irq_id_o     = id_q;
  assign core_irq_level_o  = level_q;
  assign core_irq_target_o = target_q;
  assign core_irq_err_o    = err_q;
  // CLIC acknowledge only in the very cycle the core takes the interrupt.
  assign irq_ready_o       = (state_q == S_PRESENT) & core_irq_ack_i;

endmodule

// File: doc/clic_irq_accept.md
Name: clic_irq_accept

Overview:
- Core-side stage directly downstream of the CLIC.
- Consumes the CLIC irq_valid/irq_ready/irq_id/irq_level/irq_shv handshake and filters requests against the hart's interrupt enable, threshold and current level.
- For selective-hardware-vectored (shv) interrupts, fetches the handler address from the vector table over a simple req/gnt/rvalid port, then presents a single resolved interrupt (id, level, target PC) to the core.
- The CLIC is acknowledged (irq_ready_o) only when the core takes the interrupt, so pending state is never lost.

Parameters:
- N_SOURCE, 256, number of CLIC interrupt sources.
- IRQ_ID_WIDTH, $clog2(N_SOURCE), width of interrupt id.
- ADDR_WIDTH, 32, vector-table/handler address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- irq_valid_i  in  1  CLIC has a winning interrupt.
- irq_ready_o  out  1  one-cycle acknowledge to CLIC.
- irq_id_i  in  IRQ_ID_WIDTH  winning id.
- irq_level_i  in  8  winning level.
- irq_shv_i  in  1  winning interrupt is hardware-vectored.
- mie_i  in  1  global M-mode interrupt enable.
- mintthresh_i  in  8  interrupt threshold.
- cur_level_i  in  8  current level (mintstatus.mil).
- mtvec_i  in  ADDR_WIDTH  common handler base (non-vectored).
- mtvt_i  in  ADDR_WIDTH  vector table base.
- vec_req_o  out  1  vector-table read request.
- vec_addr_o  out  ADDR_WIDTH  vector-table read address.
- vec_gnt_i  in  1  request accepted.
- vec_rvalid_i  in  1  read data valid.
- vec_rdata_i  in  ADDR_WIDTH  read data (handler address).
- vec_err_i  in  1  bus error, qualified by vec_rvalid_i.
- core_irq_req_o  out  1  interrupt presented to core.
- core_irq_ack_i  in  1  core takes interrupt.
- core_irq_id_o  out  IRQ_ID_WIDTH  latched id.
- core_irq_level_o  out  8  latched level.
- core_irq_target_o  out  ADDR_WIDTH  handler PC.
- core_irq_err_o  out  1  vector fetch failed; target is fallback.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: state IDLE; all outputs and latched registers are 0.
- Eligibility (combinational): elig = irq_valid_i & mie_i & (irq_level_i > max(mintthresh_i, cur_level_i)). The compare is an 8-bit unsigned strict greater-than.
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, PRESENT.
- IDLE:
  - If elig, latch id, level and shv.
  - If shv, go to FETCH_REQ.
  - Otherwise set target = {mtvec_i[AW-1:2], 2'b00}, err = 0, and go to PRESENT.
- FETCH_REQ:
  - vec_req_o = 1.
  - vec_addr_o = {mtvt_i[AW-1:6], 6'b0} + (id << 2). Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - vec_req_o and vec_addr_o are held stable until vec_gnt_i. On grant, go to FETCH_WAIT.
- FETCH_WAIT:
  - On vec_rvalid_i without error: target = vec_rdata_i & ~1, err = 0.
  - On vec_rvalid_i with vec_err_i: target = {mtvec_i[AW-1:2], 2'b00}, err = 1.
  - Either case goes to PRESENT.
  - The fetch is never cancelled once granted.
- PRESENT:
  - core_irq_req_o = 1, and the latched id, level, target and err are driven stable.
  - On core_irq_ack_i: irq_ready_o = 1 for exactly that cycle (combinational from ack & PRESENT), then go to IDLE.
  - Withdrawal: if mie_i = 0, or latched level <= max(mintthresh_i, cur_level_i), before ack, go to IDLE without asserting irq_ready_o. The CLIC re-presents the interrupt later.
  - Ack and withdrawal in the same cycle: ack wins.
- Withdrawal in FETCH_REQ: no request is pending on the bus, so the block returns to IDLE immediately.
- Withdrawal in FETCH_WAIT: recorded, and acted on when rvalid returns (IDLE instead of PRESENT).
- Latency:
  - Non-shv: core_irq_req_o is asserted the cycle after elig in IDLE.
  - shv: vec_req_o is asserted the cycle after elig; core_irq_req_o is asserted the cycle after vec_rvalid_i.
- No preemption: a higher-level irq arriving while not in IDLE is ignored until the block returns to IDLE. Re-evaluation happens in the first IDLE cycle.
- A CLIC id/level change while the block is busy has no effect on the latched values.
- Reset asserted mid-fetch: the FSM goes to IDLE and outputs clear. The bus side must tolerate an abandoned transaction.

Test Plan:
- Non-vectored: mie=1, thresh=0, cur=0, mtvec=0x1000_0003; CLIC id=3, level=0x80, shv=0 -> core_irq_req_o=1 the next cycle, target=0x1000_0000, id=3; ack -> irq_ready_o pulses exactly 1 cycle; back to IDLE.
- Vectored: mtvt=0x0000_2000, id=5, shv=1 -> vec_addr_o=0x0000_2014 held until gnt (gnt delayed 3 cycles); rdata=0x0000_4001 -> target=0x0000_4000, req to core the cycle after rvalid.
- Threshold: mintthresh=0x80, level=0x80 -> no accept, no irq_ready_o; level=0x81 -> accepted. With cur_level=0xC0 and level=0x90 -> not accepted.
- Withdrawal: in PRESENT, drop mie_i before ack -> core_irq_req_o falls the next cycle, irq_ready_o never asserts; with mie_i=0 and ack in the same cycle -> ack wins, ready pulses.
- Bus error: shv fetch with vec_err_i=1 and rvalid -> target = mtvec base, core_irq_err_o=1.
- Reset mid-operation: assert rst_ni low in FETCH_WAIT -> all outputs 0 immediately (async); after release, the block re-accepts the still-valid irq and issues a fresh vec_req_o.
